// File: rtl/dcache_arb_pkg.sv
// Shared types and helpers for the hart-0 data-cache request arbiter.
package dcache_arb_pkg;

   localparam int CMD_W  = 5;
   localparam int SIZE_W = 2;

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_WAIT = 2'd1,
      ST_LOCK = 2'd2
   } arb_state_e;

   // Requester-ID width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dcache_arb_src_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered DCache requests.
module dcache_arb_src_fifo
   import dcache_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ID_W  = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push,
   input  logic [ID_W-1:0] push_id,
   input  logic            pop,
   output logic [ID_W-1:0] head_id,
   output logic            full,
   output logic            empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ID_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is left unreset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_id;
   end

   assign head_id = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/dcache_req_arbiter.sv
// Arbitrates hart 0's DCache request port among NUM_REQ requesters and routes in-order responses.
// Define DCACHE_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module dcache_req_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
   input  logic [NUM_REQ*SIZE_W-1:0]   req_size,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic                        dc_req_valid,
   input  logic                        dc_req_ready,
   output logic [ADDR_W-1:0]           dc_req_addr,
   output logic [CMD_W-1:0]            dc_req_cmd,
   output logic [SIZE_W-1:0]           dc_req_size,
   output logic [DATA_W-1:0]           dc_req_data,
   input  logic                        dc_resp_valid,
   input  logic [DATA_W-1:0]           dc_resp_data,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]           resp_data,
   output logic                        err_unexpected_resp
);

   localparam int ID_W = id_width(NUM_REQ);

   localparam logic [1:0] S_ARB  = ST_ARB;
   localparam logic [1:0] S_WAIT = ST_WAIT;
   localparam logic [1:0] S_LOCK = ST_LOCK;

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   gnt_q, gnt_d;
   logic [ID_W-1:0]   arb_idx;
   logic              arb_found;
   logic [ID_W-1:0]   gnt_idx;
   logic              present;
   logic              accept;
   logic              err_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [ID_W-1:0]   head_id;
   logic              resp_pop;

   logic [ADDR_W-1:0] addr_arr [NUM_REQ];
   logic [CMD_W-1:0]  cmd_arr  [NUM_REQ];
   logic [SIZE_W-1:0] size_arr [NUM_REQ];
   logic [DATA_W-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign cmd_arr[i]  = req_cmd[i*CMD_W +: CMD_W];
      assign size_arr[i] = req_size[i*SIZE_W +: SIZE_W];
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
   end

`ifdef DCACHE_ARB_RR_EN
   logic [ID_W-1:0] rr_ptr_q;

   always_ff @(posedge clock) begin
      if (reset)
         rr_ptr_q <= '0;
      else if (accept)
         rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
   end

   always_comb begin
      int j;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!arb_found && req_valid[j]) begin
            arb_found = 1'b1;
            arb_idx   = ID_W'(j);
         end
      end
   end
`else
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            arb_found = 1'b1;
            arb_idx   = ID_W'(i);
         end
      end
   end
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_idx = gnt_q;
      present = 1'b0;
      case (state_q)
         S_ARB: begin
            gnt_idx = arb_idx;
            present = arb_found;
         end
         S_WAIT:  present = 1'b1;
         S_LOCK:  present = req_valid[gnt_q];
         default: present = 1'b0;
      endcase
      // A full FIFO blocks even a frozen grant: a response slot must exist before issue.
      if (reset || fifo_full) present = 1'b0;
   end

   assign accept       = present && dc_req_ready;
   assign dc_req_valid = present;
   assign dc_req_addr  = addr_arr[gnt_idx];
   assign dc_req_cmd   = cmd_arr[gnt_idx];
   assign dc_req_size  = size_arr[gnt_idx];
   assign dc_req_data  = data_arr[gnt_idx];

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      case (state_q)
         S_ARB: begin
            if (present) begin
               gnt_d = arb_idx;
               if (dc_req_ready) state_d = req_lock[arb_idx] ? S_LOCK : S_ARB;
               else              state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (accept) state_d = req_lock[gnt_q] ? S_LOCK : S_ARB;
         end
         S_LOCK: begin
            if (accept)
               state_d = req_lock[gnt_q] ? S_LOCK : S_ARB;
            else if (!req_valid[gnt_q] && !req_lock[gnt_q])
               state_d = S_ARB;
         end
         default: state_d = S_ARB;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_ARB;
         gnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         if (dc_resp_valid && fifo_empty) err_q <= 1'b1;
      end
   end

   dcache_arb_src_fifo #(
      .DEPTH (MAX_OUTST),
      .ID_W  (ID_W)
   ) u_src_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (accept),
      .push_id (gnt_idx),
      .pop     (resp_pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign resp_pop = dc_resp_valid && !fifo_empty && !reset;
   assign resp_data = dc_resp_data;

   always_comb begin
      resp_valid = '0;
      if (resp_pop) resp_valid[head_id] = 1'b1;
   end

   assign err_unexpected_resp = err_q;

endmodule
